// File: rtl/if_instr_buffer.sv
// Instruction queue between the I-cache fetch return path and the IF/ID register.
// Optional same-cycle bypass when empty: define IF_INSTR_BUFFER_BYPASS_EN.
module if_instr_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             in_exception,
    input  logic [4:0]       in_exccode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic             out_exception,
    output logic [4:0]       out_exccode,
    output logic [PTR_W:0]   count
);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic             exc_mem   [DEPTH];
    logic [4:0]       code_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             exc_block;

    logic             stored_valid;
    logic             full;
    logic             pop_stored;
    logic             push;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;

    assign stored_valid = (count_q != '0);
    assign full         = (count_q == (PTR_W + 1)'(DEPTH));

    // pop is derived from stored entries only, so in_ready never depends on out_valid
    assign pop_stored   = stored_valid & out_ready;
    assign in_ready     = !flush & !exc_block & (!full | pop_stored);
    assign push         = in_valid & in_ready;

`ifdef IF_INSTR_BUFFER_BYPASS_EN
    assign bypass = !stored_valid & push & out_ready;
`else
    assign bypass = 1'b0;
`endif

    // flush wins over a head pop; in_ready already masks pushes during flush
    assign wr_en     = push & !bypass;
    assign rd_en     = pop_stored & !flush;
    assign out_valid = stored_valid | bypass;
    assign count     = count_q;

    always_comb begin
        out_pc        = '0;
        out_instr     = '0;
        out_exception = 1'b0;
        out_exccode   = '0;
        if (bypass) begin
            out_pc        = in_pc;
            out_instr     = in_instr;
            out_exception = in_exception;
            out_exccode   = in_exccode;
        end else if (stored_valid) begin
            out_pc        = pc_mem[rd_ptr];
            out_instr     = instr_mem[rd_ptr];
            out_exception = exc_mem[rd_ptr];
            out_exccode   = code_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
            exc_mem[wr_ptr]   <= in_exception;
            code_mem[wr_ptr]  <= in_exccode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            exc_block <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            exc_block <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // a faulting fetch stops intake until the pipeline redirects
            if (push && in_exception) exc_block <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_instr_buffer.sv
// Bench for if_instr_buffer: fixed vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_if_instr_buffer;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             in_exception;
    logic [4:0]       in_exccode;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic             out_exception;
    logic [4:0]       out_exccode;
    logic [PTR_W:0]   count;

    if_instr_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .in_exception(in_exception), .in_exccode(in_exccode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_exception(out_exception), .out_exccode(out_exccode),
        .count(count)
    );

    always #5 clk = ~clk;

    // reference model: entries as {pc, instr, exc, code}
    logic [69:0] exp_q[$];
    logic        blk;
    int          n_vec = 0;
    int          n_mis = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] instr, input logic exc, input logic [4:0] code,
                         input logic ordy);
        flush        = fl;
        in_valid     = iv;
        in_pc        = pc;
        in_instr     = instr;
        in_exception = exc;
        in_exccode   = code;
        out_ready    = ordy;
    endtask

    // One clock: drive, check against model, advance model and clock.
    task automatic cycle(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] instr, input logic exc, input logic [4:0] code,
                         input logic ordy);
        int          sz;
        logic        rdy;
        logic        ov;
        logic        byp;
        logic [69:0] head;
        drive(fl, iv, pc, instr, exc, code, ordy);
        #1;
        sz  = exp_q.size();
        rdy = !fl && !blk && (sz < DEPTH || (sz != 0 && ordy));
        byp = 1'b0;
`ifdef IF_INSTR_BUFFER_BYPASS_EN
        byp = (sz == 0) && iv && rdy && ordy;
`endif
        ov   = (sz != 0) || byp;
        head = byp ? {pc, instr, exc, code} : ((sz != 0) ? exp_q[0] : 70'd0);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("out_pc", out_pc, head[69:38]);
        chk("out_instr", out_instr, head[37:6]);
        chk("out_exception", 32'(out_exception), 32'(head[5]));
        chk("out_exccode", 32'(out_exccode), 32'(head[4:0]));
        chk("count", 32'(count), 32'(sz));
        if (fl) begin
            exp_q.delete();
            blk = 1'b0;
        end else begin
            if (sz != 0 && ordy) void'(exp_q.pop_front());
            if (iv && rdy) begin
                if (!byp) exp_q.push_back({pc, instr, exc, code});
                if (exc) blk = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b0);
    endtask

    task automatic push_one(input logic [31:0] pc, input logic ordy);
        cycle(1'b0, 1'b1, pc, pc ^ 32'hA5A5_0000, 1'b0, 5'h0, ordy);
    endtask

    initial begin
        // table: inputs then expectations seen before the edge of that cycle
        tbl[0]  = '{1'b0, 1'b1, 32'hBFC00000, 1'b0, 1'b1, 1'b0, 32'h0,        0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hBFC00000, 1};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hBFC00000, 1};
        tbl[3]  = '{1'b0, 1'b1, 32'h00,       1'b0, 1'b1, 1'b0, 32'h0,        0};
        tbl[4]  = '{1'b0, 1'b1, 32'h04,       1'b0, 1'b1, 1'b1, 32'h0,        1};
        tbl[5]  = '{1'b0, 1'b1, 32'h08,       1'b0, 1'b1, 1'b1, 32'h0,        2};
        tbl[6]  = '{1'b0, 1'b1, 32'h0C,       1'b0, 1'b1, 1'b1, 32'h0,        3};
        tbl[7]  = '{1'b0, 1'b1, 32'h10,       1'b0, 1'b0, 1'b1, 32'h0,        4};
        tbl[8]  = '{1'b0, 1'b1, 32'h10,       1'b1, 1'b1, 1'b1, 32'h0,        4};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h04,       4};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h08,       3};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0C,       2};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h10,       1};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        0};

        // clock/reset
        rst = 1'b1;
        blk = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset in_ready (rst high)", 32'(in_ready), 32'd1);
        chk("reset out_pc", out_pc, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // table vectors (first entry uses the boot instruction word)
        for (int i = 0; i < 15; i++) begin
            logic [31:0] instr;
            instr = (i == 0) ? 32'h24010001 : (tbl[i].pc ^ 32'hA5A5_0000);
            drive(tbl[i].fl, tbl[i].iv, tbl[i].pc, instr, 1'b0, 5'h0, tbl[i].ordy);
            #1;
            chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d out_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
            cycle(tbl[i].fl, tbl[i].iv, tbl[i].pc, instr, 1'b0, 5'h0, tbl[i].ordy);
        end

        // streaming push/pop across pointer wrap
        for (int i = 0; i < 10; i++) push_one(32'h100 + 32'(i * 4), 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b1);

        // faulting fetch blocks intake until flush
        cycle(1'b0, 1'b1, 32'h200, 32'hDEAD0001, 1'b1, 5'h04, 1'b0);
        push_one(32'h204, 1'b0);
        push_one(32'h208, 1'b0);
        chk("exc blocked out_exccode", 32'(out_exccode), 32'h04);
        push_one(32'h20C, 1'b1);
        push_one(32'h210, 1'b1);
        chk("exc still blocked in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b0);
        push_one(32'h300, 1'b0);

        // flush with simultaneous push and pop at count=3
        push_one(32'h304, 1'b0);
        push_one(32'h308, 1'b0);
        cycle(1'b1, 1'b1, 32'h30C, 32'h0, 1'b0, 5'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b1);

        // asynchronous reset between edges with two entries queued
        push_one(32'h400, 1'b0);
        push_one(32'h404, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst count", 32'(count), 32'd0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        blk = 1'b0;
        #1;
        chk("after rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [31:0] r;
            r = $urandom;
            cycle($urandom_range(0, 15) == 0, r[0], r, $urandom,
                  $urandom_range(0, 24) == 0, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
